// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the D-stage hazard scoreboard and the multiply/divide busy tracker.
// Forward-select encodings, the Tuse "operand not read" marker and default md latencies.
package hazard_scoreboard_pkg;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_W  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_E  = 2'd3;

    // All-ones Tuse means the operand is never read, so it can never stall.
    localparam logic [1:0] TUSE_NONE = 2'b11;

    localparam int MD_MULT_LAT = 5;
    localparam int MD_DIV_LAT  = 10;

endpackage

// File: rtl/hazard_scoreboard_md_busy.sv
// Multiply/divide occupancy counter: loads a latency, counts down to zero, busy while nonzero.
// Shared with the E-stage multdiv unit so both agree on when HI/LO become available.
module md_busy_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);

    logic [CNT_W-1:0] cnt_p0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_p0 <= '0;
        end else if (load) begin
            cnt_p0 <= load_val;
        end else if (cnt_p0 != '0) begin
            cnt_p0 <= cnt_p0 - 1'b1;
        end
    end

    assign busy = (cnt_p0 != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard: per-register in-flight producer state (valid, age, remaining Tnew)
// drives stall and forward selects; a busy counter covers HI/LO hazards of mult/div.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int TNEW_W   = 2,
    parameter int DEPTH    = 3,
    parameter int MULT_LAT = MD_MULT_LAT,
    parameter int DIV_LAT  = MD_DIV_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [TNEW_W-1:0] tuse_rs,
    input  logic [TNEW_W-1:0] tuse_rt,
    input  logic [ADDR_W-1:0] dst,
    input  logic [TNEW_W-1:0] tnew,
    input  logic              md_start,
    input  logic              md_div,
    input  logic              md_use,
    output logic              stall,
    output logic              md_busy,
    output logic [1:0]        fwd_rs_op,
    output logic [1:0]        fwd_rt_op
);

    localparam int NREG   = 1 << ADDR_W;
    localparam int AGE_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MD_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W  = $clog2(MD_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(DEPTH - 1);

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    // Ready producers forward from the stage they currently occupy: E=DEPTH, then down to W=1.
    function automatic logic [1:0] fwd_sel(input logic hit, input logic [TNEW_W-1:0] r,
                                           input logic [AGE_W-1:0] a);
        if (hit && r == '0) begin
            return 2'(DEPTH - int'(a));
        end
        return FWD_RF;
    endfunction

    logic              vld_p0 [NREG];
    logic [AGE_W-1:0]  age_p0 [NREG];
    logic [TNEW_W-1:0] rem_p0 [NREG];

    logic hit_rs, hit_rt;
    logic stall_rs, stall_rt;
    logic issue;
    logic md_load;
    logic [CNT_W-1:0] md_load_val;

    assign hit_rs   = (rs != '0) && vld_p0[rs];
    assign hit_rt   = (rt != '0) && vld_p0[rt];
    assign stall_rs = hit_rs && (rem_p0[rs] > tuse_rs);
    assign stall_rt = hit_rt && (rem_p0[rt] > tuse_rt);

    assign stall     = stall_rs | stall_rt | (md_busy & (md_start | md_use));
    assign fwd_rs_op = fwd_sel(hit_rs, rem_p0[rs], age_p0[rs]);
    assign fwd_rt_op = fwd_sel(hit_rt, rem_p0[rt], age_p0[rt]);

    // A stalled instruction becomes the bubble entering E, so it writes nothing.
    assign issue       = !stall && (dst != '0);
    assign md_load     = md_start && !stall;
    assign md_load_val = md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

    // ---- D -> E boundary: producers advance every edge; a new issue overrides its own entry ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                vld_p0[r] <= 1'b0;
            end
        end else begin
            vld_p0[0] <= 1'b0;
            for (int r = 1; r < NREG; r++) begin
                if (issue && dst == ADDR_W'(r)) begin
                    vld_p0[r] <= 1'b1;
                end else if (vld_p0[r] && age_p0[r] == AGE_LAST) begin
                    vld_p0[r] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NREG; r++) begin
            if (issue && dst == ADDR_W'(r)) begin
                age_p0[r] <= '0;
                rem_p0[r] <= tnew;
            end else begin
                age_p0[r] <= age_p0[r] + 1'b1;
                rem_p0[r] <= sat_dec(rem_p0[r]);
            end
        end
    end

    md_busy_counter #(
        .CNT_W (CNT_W)
    ) u_md_busy (
        .clk      (clk),
        .reset    (reset),
        .load     (md_load),
        .load_val (md_load_val),
        .busy     (md_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic, checked
// against an issue-history model (what issued k cycles ago) rather than per-register state.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int ADDR_W   = 5;
    localparam int TNEW_W   = 2;
    localparam int DEPTH    = 3;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int NU       = int'(TUSE_NONE);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] rs = '0, rt = '0, dst = '0;
    logic [TNEW_W-1:0] tuse_rs = '1, tuse_rt = '1, tnew = '0;
    logic              md_start = 1'b0, md_div = 1'b0, md_use = 1'b0;
    logic              stall, md_busy;
    logic [1:0]        fwd_rs_op, fwd_rt_op;

    hazard_scoreboard #(
        .ADDR_W(ADDR_W), .TNEW_W(TNEW_W), .DEPTH(DEPTH),
        .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk(clk), .reset(reset), .rs(rs), .rt(rt), .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
        .dst(dst), .tnew(tnew), .md_start(md_start), .md_div(md_div), .md_use(md_use),
        .stall(stall), .md_busy(md_busy), .fwd_rs_op(fwd_rs_op), .fwd_rt_op(fwd_rt_op)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Issue history: index k holds the write issued k+1 edges ago (0 = no write).
    int h_dst  [DEPTH];
    int h_tnew [DEPTH];
    int edge_cnt   = 0;
    int md_free_at = 0;

    int obs_stall, obs_busy, obs_fwd_rs, obs_fwd_rt;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int k = 0; k < DEPTH; k++) begin
            h_dst[k]  = 0;
            h_tnew[k] = 0;
        end
        md_free_at = edge_cnt;
    endfunction

    // Most recent writer of r within the forwarding window; its remaining Tnew is tnew minus
    // the edges it has spent beyond E, floored at zero.
    function automatic void src_model(input int r, output bit hit, output int rem_o,
                                      output int age_o);
        hit = 0; rem_o = 0; age_o = 0;
        if (r != 0) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!hit && h_dst[k] == r) begin
                    hit   = 1;
                    age_o = k;
                    rem_o = (h_tnew[k] > k) ? h_tnew[k] - k : 0;
                end
            end
        end
    endfunction

    task automatic cycle(input int a_rs, input int a_rt, input int a_tu_rs, input int a_tu_rt,
                         input int a_dst, input int a_tnew,
                         input bit a_ms, input bit a_md, input bit a_mu);
        bit h_rs, h_rt, e_busy, e_stall;
        int r_rs, r_rt, g_rs, g_rt, e_frs, e_frt;
        @(negedge clk);
        rs = ADDR_W'(a_rs); rt = ADDR_W'(a_rt);
        tuse_rs = TNEW_W'(a_tu_rs); tuse_rt = TNEW_W'(a_tu_rt);
        dst = ADDR_W'(a_dst); tnew = TNEW_W'(a_tnew);
        md_start = a_ms; md_div = a_md; md_use = a_mu;
        #1;
        src_model(a_rs, h_rs, r_rs, g_rs);
        src_model(a_rt, h_rt, r_rt, g_rt);
        e_busy  = edge_cnt < md_free_at;
        e_stall = (h_rs && r_rs > a_tu_rs) || (h_rt && r_rt > a_tu_rt) || (e_busy && (a_ms || a_mu));
        e_frs   = (h_rs && r_rs == 0) ? DEPTH - g_rs : 0;
        e_frt   = (h_rt && r_rt == 0) ? DEPTH - g_rt : 0;
        obs_stall = int'(stall); obs_busy = int'(md_busy);
        obs_fwd_rs = int'(fwd_rs_op); obs_fwd_rt = int'(fwd_rt_op);
        check_eq("stall", obs_stall, int'(e_stall));
        check_eq("md_busy", obs_busy, int'(e_busy));
        check_eq("fwd_rs_op", obs_fwd_rs, e_frs);
        check_eq("fwd_rt_op", obs_fwd_rt, e_frt);
        @(posedge clk);
        for (int k = DEPTH - 1; k > 0; k--) begin
            h_dst[k]  = h_dst[k-1];
            h_tnew[k] = h_tnew[k-1];
        end
        h_dst[0]  = (!e_stall && a_dst != 0) ? a_dst : 0;
        h_tnew[0] = a_tnew;
        edge_cnt++;
        if (a_ms && !e_stall) md_free_at = edge_cnt + (a_md ? DIV_LAT : MULT_LAT);
    endtask

    task automatic nop();
        cycle(0, 0, NU, NU, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        model_clear();
        #2;
        check_eq("rst_stall", int'(stall), 0);
        check_eq("rst_md_busy", int'(md_busy), 0);
        check_eq("rst_fwd_rs", int'(fwd_rs_op), 0);
        check_eq("rst_fwd_rt", int'(fwd_rt_op), 0);
        @(negedge clk);
        reset = 1'b1;

        // lw $2 then add $3,$2,$4: one stall, then no forward, then W forward
        cycle(0, 0, NU, NU, 2, 2, 0, 0, 0);
        cycle(2, 4, 1, 1, 3, 1, 0, 0, 0);
        check_eq("lw_use_stall", obs_stall, 1);
        cycle(2, 4, 1, 1, 3, 1, 0, 0, 0);
        check_eq("lw_use_go", obs_stall, 0);
        check_eq("lw_use_fwd_late", obs_fwd_rs, int'(FWD_RF));
        cycle(2, 0, 1, NU, 0, 0, 0, 0, 0);
        check_eq("lw_fwd_w", obs_fwd_rs, int'(FWD_W));

        // addu $5 then beq $5: one stall, then forward from M
        cycle(0, 0, NU, NU, 5, 1, 0, 0, 0);
        cycle(5, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("beq_stall", obs_stall, 1);
        cycle(5, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("beq_go", obs_stall, 0);
        check_eq("beq_fwd_m", obs_fwd_rs, int'(FWD_M));

        // jal $31 then jr $31 immediately, and again two cycles later
        cycle(0, 0, NU, NU, 31, 0, 0, 0, 0);
        cycle(31, 0, 0, NU, 0, 0, 0, 0, 0);
        check_eq("jr_no_stall", obs_stall, 0);
        check_eq("jr_fwd_e", obs_fwd_rs, int'(FWD_E));
        cycle(0, 0, NU, NU, 31, 0, 0, 0, 0);
        nop(); nop();
        cycle(31, 0, 0, NU, 0, 0, 0, 0, 0);
        check_eq("jr_late_fwd_w", obs_fwd_rs, int'(FWD_W));

        // ori $6 then lw $6: the newer producer decides; self-reference never stalls
        cycle(0, 0, NU, NU, 6, 1, 0, 0, 0);
        cycle(0, 0, NU, NU, 6, 2, 0, 0, 0);
        cycle(6, 0, 1, NU, 0, 0, 0, 0, 0);
        check_eq("ori_lw_stall", obs_stall, 1);
        cycle(7, 0, 1, NU, 7, 1, 0, 0, 0);
        check_eq("self_dst_no_stall", obs_stall, 0);

        // mult then mfhi: exactly MULT_LAT stalls; div likewise with DIV_LAT
        nop(); nop();
        cycle(0, 0, NU, NU, 0, 0, 1, 0, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 0, NU, NU, 0, 0, 0, 0, 1);
            if (obs_stall == 0) break;
            n++;
        end
        check_eq("mult_stall_cycles", n, MULT_LAT);
        cycle(0, 0, NU, NU, 0, 0, 1, 1, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 0, NU, NU, 0, 0, 0, 0, 1);
            if (obs_stall == 0) break;
            n++;
        end
        check_eq("div_stall_cycles", n, DIV_LAT);
        cycle(0, 0, NU, NU, 0, 0, 1, 0, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(0, 0, NU, NU, 0, 0, 1, 0, 0);
            if (obs_stall == 0) break;
            n++;
        end
        check_eq("mult_mult_stall_cycles", n, MULT_LAT);
        check_eq("mult_mult_busy_end", obs_busy, 0);

        // pending lw plus busy div, then asynchronous reset between edges
        for (int i = 0; i < 6; i++) nop();
        cycle(0, 0, NU, NU, 2, 2, 0, 0, 0);
        cycle(0, 0, NU, NU, 0, 0, 1, 1, 0);
        cycle(2, 0, 0, NU, 0, 0, 0, 0, 0);
        check_eq("pre_rst_stall", obs_stall, 1);
        check_eq("pre_rst_busy", obs_busy, 1);
        @(negedge clk);
        rs = 5'd2; tuse_rs = '0; md_use = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_eq("mid_rst_stall", int'(stall), 0);
        check_eq("mid_rst_md_busy", int'(md_busy), 0);
        check_eq("mid_rst_fwd_rs", int'(fwd_rs_op), 0);
        check_eq("mid_rst_fwd_rt", int'(fwd_rt_op), 0);
        rs = '0; rt = '0; dst = '0; md_start = 1'b0; md_use = 1'b0;
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        cycle(2, 0, 0, NU, 0, 0, 0, 0, 0);
        check_eq("post_rst_fwd_rs", obs_fwd_rs, 0);
        check_eq("post_rst_stall", obs_stall, 0);

        // random traffic over a small register window to provoke overlaps
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 7), $urandom_range(0, 3),
                  ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Sequential successor to the combinational D-stage stall/forward logic. It keeps a per-register scoreboard of in-flight producers, with their remaining Tnew and pipeline age, so stall and D-stage forward selects come from stored state. Reg-file size, Tnew width and pipeline depth are parametrised. It adds a multiply/divide busy tracker (HI/LO hazards). It sits beside the D-stage decoder, which supplies rs/rt, Tuse, destination and Tnew of the instruction in D.

Parameters:
ADDR_W, 5, register address width; scoreboard holds 2**ADDR_W entries, entry 0 never valid
TNEW_W, 2, width of Tnew/Tuse fields
DEPTH, 3, stages after D that can forward (age 0=E, 1=M, 2=W)
MULT_LAT, 5, busy cycles after a mult/multu issue
DIV_LAT, 10, busy cycles after a div/divu issue

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
rs  in  ADDR_W  source 1 of instruction in D
rt  in  ADDR_W  source 2 of instruction in D
tuse_rs  in  TNEW_W  Tuse of rs (max value = not used)
tuse_rt  in  TNEW_W  Tuse of rt
dst  in  ADDR_W  destination of instruction in D; 0 = no write
tnew  in  TNEW_W  Tnew of instruction in D, counted from entry to E
md_start  in  1  instruction in D is mult/multu/div/divu
md_div  in  1  qualifies md_start: 1 = divide latency
md_use  in  1  instruction in D is mfhi/mflo/mthi/mtlo
stall  out  1  hold PC and F/D, insert bubble into E
md_busy  out  1  multiply/divide unit occupied
fwd_rs_op  out  2  3=from E, 2=from M, 1=from W, 0=register file
fwd_rt_op  out  2  same encoding for rt

Behaviour:
- Entry[r] = {valid, age (clog2(DEPTH) bits), rem (TNEW_W bits)}.
- Reset (asynchronous, active-low): all entries invalid, md counter 0. Outputs: stall=0, md_busy=0, fwd ops=0.
- Reset asserted mid-operation discards all tracked producers immediately.
- All outputs are combinational from the current state and current D inputs. No extra latency.
- A source operand hits when its address is nonzero and entry[addr].valid is set.
- stall_rs = hit & rem > tuse_rs. stall_rt is defined the same way.
- stall = stall_rs | stall_rt | (md_busy & (md_start | md_use)).
- fwd_rs_op = hit & rem==0 ? (DEPTH - age) : 0. With DEPTH=3: age 0→3, 1→2, 2→1. fwd_rt_op is defined the same way.
- If hit & rem>0 & no stall: fwd_op=0. The consumer reads at a later stage, and forwarding there is handled downstream.
- Every clock edge, all valid entries advance whether or not stall is set, because stages after D always flow:
  - age+1
  - rem = rem==0 ? 0 : rem-1 (saturating)
  - An entry at age DEPTH-1 becomes invalid.
- Issue occurs when stall==0 and dst!=0. Entry[dst] is loaded with {1, 0, tnew}. This write overrides the advance of that same entry, so the newest producer always wins.
- The stall check uses pre-update state. An instruction with dst==rs does not hazard on itself.
- When stall==1 nothing is written, which matches the bubble entering E.
- md counter:
  - Loads MULT_LAT or DIV_LAT (selected by md_div) on md_start & !stall.
  - Otherwise it decrements, saturating at 0.
  - md_busy = counter!=0.
- md_start while busy stalls until the counter reaches 0, then issues.
- md_use in the same cycle as the counter reaches 0 does not stall.

Decomposition:
- Shared package holds:
  - fwd op encodings FWD_RF/FWD_W/FWD_M/FWD_E
  - the Tuse "not used" constant (all ones)
  - default latencies MULT_LAT/DIV_LAT
- Natural sub-module: md_busy_counter (load/decrement/busy), reusable by the E-stage multdiv unit.

Test Plan:
- lw $2 (tnew=2) issued, next cycle add $3,$2,$4 (tuse_rs=1) → stall=1 for one cycle, then stall=0, fwd_rs_op=0; W-age hit the following cycle gives fwd_rs_op=1.
- addu $5 (tnew=1), then beq $5,$0 (tuse=0) → stall=1 one cycle, then fwd_rs_op=2 (from M).
- jal $31 (tnew=0), then jr $31 → no stall, fwd_rs_op=3; if the jr is delayed 2 cycles, fwd_rs_op=1.
- ori $6 then lw $6 back-to-back, then add using $6 (tuse=1) → stall decided by the lw entry (rem=2→stall) though the ori entry is ready; dst=0 writes never set stall.
- mult issued, mfhi next cycle → md_busy=1, stall=1 for exactly MULT_LAT cycles; div with DIV_LAT=10 → 10 stall cycles; second mult while busy waits likewise.
- Pending lw entry plus busy div, reset driven low between edges → stall, md_busy, fwd ops all 0 immediately; after release, the same rs reads fwd_op=0.
